// File: rtl/case4_sweep_ctrl.sv
// Exhaustive 128-vector sweep controller for the 7-input/3-output case4 block.
// Drives each vector, waits SETTLE cycles, then grades the responses.
module case4_sweep_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic [6:0] dut_in,
    input  logic       dut_x,
    input  logic       dut_y,
    input  logic       dut_z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [6:0] first_fail,
    output logic       first_fail_valid
);

    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [6:0] din_nx;
    logic [7:0] err_nx;
    logic [6:0] ff_nx;
    logic       ffv_nx;
    logic       pass_nx;

    logic gold_x, gold_y, gold_z;
    logic miss;

    // Bit order {a,b,c,d,e,f,g} = dut_in[6:0]
    assign gold_x = dut_in[6] & dut_in[5] & dut_in[2];
    assign gold_y = ~(dut_in[5] & dut_in[3] & dut_in[2]);
    assign gold_z = ~(&dut_in[4:0]);
    assign miss   = (dut_x != gold_x) | (dut_y != gold_y) | (dut_z != gold_z);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        din_nx   = dut_in;
        err_nx   = err_count;
        ff_nx    = first_fail;
        ffv_nx   = first_fail_valid;
        pass_nx  = pass;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx = HOLD;
                    cnt_nx   = SETTLE_L;
                    din_nx   = '0;
                    err_nx   = '0;
                    ff_nx    = '0;
                    ffv_nx   = 1'b0;
                    pass_nx  = 1'b0;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (cnt <= 4'd1) begin
                    state_nx = SAMPLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            SAMPLE: begin
                // An aborted sample is dropped, so partial results stay intact
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    if (miss) begin
                        err_nx = err_count + 8'd1;
                        if (!first_fail_valid) begin
                            ff_nx  = dut_in;
                            ffv_nx = 1'b1;
                        end
                    end
                    if (dut_in != 7'h7F) begin
                        din_nx   = dut_in + 7'd1;
                        cnt_nx   = SETTLE_L;
                        state_nx = HOLD;
                    end else begin
                        state_nx = DONE;
                        pass_nx  = (err_count == 8'd0) && !miss;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            dut_in           <= '0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
        end else begin
            state            <= state_nx;
            cnt              <= cnt_nx;
            dut_in           <= din_nx;
            err_count        <= err_nx;
            first_fail       <= ff_nx;
            first_fail_valid <= ffv_nx;
            pass             <= pass_nx;
        end
    end

endmodule

// File: tb/tb_case4_sweep_ctrl.sv
// Bench for case4_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) driving
// a behavioural case4 block with selectable faults; results go via a scoreboard.
module tb_case4_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start0, abort0, x0, y0, z0, busy0, done0, pass0, ffv0;
    logic start1, abort1, x1, y1, z1, busy1, done1, pass1, ffv1;
    logic [6:0] din0, din1, ff0, ff1;
    logic [7:0] err0, err1;
    int fault0, fault1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [7:0] err;
        logic [6:0] ff;
        logic       ffv;
        logic       pass;
        logic [6:0] din;
    } exp_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       pass;
        logic [7:0] err;
        logic [6:0] ff;
        logic       ffv;
        logic [6:0] din;
    } obs_t;

    exp_t sb[$];

    case4_sweep_ctrl #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .dut_in(din0), .dut_x(x0), .dut_y(y0), .dut_z(z0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail(ff0), .first_fail_valid(ffv0)
    );

    case4_sweep_ctrl #(.SETTLE(3)) u_s3 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .dut_in(din1), .dut_x(x1), .dut_y(y1), .dut_z(z1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail(ff1), .first_fail_valid(ffv1)
    );

    // Reference case4 function, returns {x,y,z}
    function automatic logic [2:0] golden(logic [6:0] v);
        logic a, b, c, d, e, f, g;
        {a, b, c, d, e, f, g} = v;
        return {a & b & e, ~(b & d & e), ~(c & d & e & f & g)};
    endfunction

    // 0 good, 1 x stuck-at-0, 2 y stuck-at-1, 3 z inverted
    function automatic logic [2:0] resp(logic [6:0] v, int flt);
        logic [2:0] r;
        r = golden(v);
        case (flt)
            1: r[2] = 1'b0;
            2: r[1] = 1'b1;
            3: r[0] = ~r[0];
            default: ;
        endcase
        return r;
    endfunction

    assign {x0, y0, z0} = resp(din0, fault0);
    assign {x1, y1, z1} = resp(din1, fault1);

    function automatic exp_t model(int flt, int nvec);
        exp_t e;
        logic [6:0] v;
        e = '0;
        for (int k = 0; k < nvec; k++) begin
            v = 7'(k);
            if (resp(v, flt) != golden(v)) begin
                e.err = e.err + 8'd1;
                if (!e.ffv) begin
                    e.ff  = v;
                    e.ffv = 1'b1;
                end
            end
        end
        e.din  = (nvec >= 128) ? 7'h7F : 7'(nvec);
        e.pass = (nvec >= 128) && (e.err == 8'd0);
        return e;
    endfunction

    function automatic obs_t obs(int i);
        if (i == 0) return {busy0, done0, pass0, err0, ff0, ffv0, din0};
        return {busy1, done1, pass1, err1, ff1, ffv1, din1};
    endfunction

    task automatic set_start(int i, logic v);
        if (i == 0) start0 = v;
        else start1 = v;
    endtask

    task automatic set_abort(int i, logic v);
        if (i == 0) abort0 = v;
        else abort1 = v;
    endtask

    task automatic set_fault(int i, int f);
        if (i == 0) fault0 = f;
        else fault1 = f;
    endtask

    task automatic chk(string tag, int got, int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmp_result(string tag, obs_t o, exp_t e);
        chk({tag, "_err"}, int'(o.err), int'(e.err));
        chk({tag, "_ff"}, int'(o.ff), int'(e.ff));
        chk({tag, "_ffv"}, int'(o.ffv), int'(e.ffv));
        chk({tag, "_pass"}, int'(o.pass), int'(e.pass));
        chk({tag, "_din"}, int'(o.din), int'(e.din));
    endtask

    task automatic sweep(string tag, int i, int f, int settle, bit repulse);
        obs_t o;
        exp_t e;
        int n;
        bit seen;
        set_fault(i, f);
        sb.push_back(model(f, 128));
        set_start(i, 1'b1);
        n = 0;
        seen = 1'b0;
        o = '0;
        while (n < 4000 && !seen) begin
            @(negedge clk);
            n++;
            set_start(i, (repulse && n == 100) ? 1'b1 : 1'b0);
            o = obs(i);
            if (o.done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, int'(seen), 1);
        chk({tag, "_latency"}, n - 1, 128 * (settle + 1));
        e = sb.pop_front();
        cmp_result(tag, o, e);
        @(negedge clk);
        o = obs(i);
        chk({tag, "_done_pulse"}, int'(o.done), 0);
        chk({tag, "_busy_after"}, int'(o.busy), 0);
    endtask

    task automatic abort_run(string tag, int i, int f, int w, int nvec);
        obs_t o;
        exp_t e;
        bit seen;
        set_fault(i, f);
        sb.push_back(model(f, nvec));
        set_start(i, 1'b1);
        repeat (w) begin
            @(negedge clk);
            set_start(i, 1'b0);
        end
        set_abort(i, 1'b1);
        @(negedge clk);
        set_abort(i, 1'b0);
        o = obs(i);
        e = sb.pop_front();
        chk({tag, "_busy"}, int'(o.busy), 0);
        cmp_result(tag, o, e);
        seen = o.done;
        repeat (4) begin
            @(negedge clk);
            o = obs(i);
            if (o.done) seen = 1'b1;
        end
        chk({tag, "_no_done"}, int'(seen), 0);
    endtask

    initial begin
        obs_t o;
        rst = 1'b1;
        start0 = 1'b0; abort0 = 1'b0;
        start1 = 1'b0; abort1 = 1'b0;
        fault0 = 0; fault1 = 0;
        repeat (2) @(negedge clk);
        o = obs(0);
        chk("rst_busy", int'(o.busy), 0);
        chk("rst_done", int'(o.done), 0);
        cmp_result("rst", o, '0);
        rst = 1'b0;
        @(negedge clk);

        sweep("good", 0, 0, 1, 1'b0);
        sweep("xs0", 0, 1, 1, 1'b0);
        sweep("ys1", 0, 2, 1, 1'b0);
        sweep("zinv", 0, 3, 1, 1'b0);
        sweep("s3_repulse", 1, 0, 3, 1'b1);

        abort_run("abort_hold", 1, 3, 50, 12);
        abort_run("abort_sample", 0, 3, 12, 5);

        // start with abort in IDLE must not launch, and results stay put
        set_start(0, 1'b1);
        set_abort(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        set_abort(0, 1'b0);
        o = obs(0);
        chk("sa_busy", int'(o.busy), 0);
        chk("sa_err_hold", int'(o.err), 5);
        @(negedge clk);
        o = obs(0);
        chk("sa_busy2", int'(o.busy), 0);

        set_fault(0, 3);
        set_start(0, 1'b1);
        repeat (30) begin
            @(negedge clk);
            set_start(0, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        o = obs(0);
        chk("mrst_busy", int'(o.busy), 0);
        chk("mrst_done", int'(o.done), 0);
        cmp_result("mrst", o, '0);
        @(negedge clk);
        sweep("post_rst", 0, 0, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/case4_sweep_ctrl.md
CASE4_SWEEP_CTRL -- requirements
Module: case4_sweep_ctrl

Interface
REQ-001 Parameter: SETTLE, default 1, number of cycles each vector is held before sampling; legal range 1..15.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset; synchronous, active-high.
REQ-004 Port: start  in  1  request a full 128-vector sweep; sampled only in IDLE.
REQ-005 Port: abort  in  1  terminate a sweep in progress.
REQ-006 Port: dut_in  out  7  stimulus {a,b,c,d,e,f,g}, a = bit 6, g = bit 0; registered.
REQ-007 Port: dut_x, dut_y, dut_z  in  1 each  DUT responses.
REQ-008 Port: busy  out  1  high in every non-IDLE state.
REQ-009 Port: done  out  1  single-cycle pulse on sweep completion.
REQ-010 Port: pass  out  1  high when the last completed sweep had zero mismatches.
REQ-011 Port: err_count  out  8  number of mismatching vectors in the current or last sweep.
REQ-012 Port: first_fail  out  7  first mismatching vector (lowest index).
REQ-013 Port: first_fail_valid  out  1  first_fail holds a captured vector.

Function
REQ-014 Golden model SHALL be: x = a&b&e; y = ~(b&d&e); z = ~(c&d&e&f&g).
REQ-015 A vector mismatches when any of dut_x/dut_y/dut_z differs from the golden value for the current dut_in.
REQ-016 FSM states SHALL be IDLE, HOLD, SAMPLE and DONE.
REQ-017 IDLE, start=1, abort=0: next cycle dut_in=0, err_count=0, first_fail=0, first_fail_valid=0, pass=0; go to HOLD with the settle counter loaded to SETTLE.
REQ-018 HOLD SHALL last exactly SETTLE cycles, with dut_in stable, then go to SAMPLE.
REQ-019 SAMPLE SHALL last one cycle and compare the DUT outputs against the golden model for dut_in.
REQ-020 On a SAMPLE mismatch: err_count increments; if first_fail_valid=0, first_fail<=dut_in and first_fail_valid<=1.
REQ-021 SAMPLE with dut_in!=127: dut_in increments by 1; go to HOLD with the counter reloaded.
REQ-022 SAMPLE with dut_in==127: go to DONE.
REQ-023 DONE SHALL last one cycle with done=1 and pass=(err_count==0), then return to IDLE.
REQ-024 Sweep latency SHALL be 128*(SETTLE+1) cycles from the start-accept edge to DONE entry.
REQ-025 dut_in SHALL NOT wrap; it holds 127 after completion.
REQ-026 err_count SHALL NOT exceed 128; no saturation logic is needed.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 abort in HOLD or SAMPLE: go to IDLE next cycle; no done pulse; pass stays 0.
REQ-029 Results from an aborted SAMPLE cycle's comparison SHALL be discarded; partial err_count and first_fail are held.
REQ-030 start and abort in the same IDLE cycle: abort wins; stay in IDLE.
REQ-031 abort in DONE SHALL be ignored; done still pulses.
REQ-032 All result outputs SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-033 rst=1 at a clock edge: state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_valid=0.
REQ-034 Reset SHALL override start and abort and take effect mid-sweep from the next edge.

Verification
REQ-035 Correct combinational DUT, SETTLE=1; pulse start -> busy for 256 cycles, then done for 1 cycle; err_count=0, pass=1, first_fail_valid=0, dut_in=0x7F.
REQ-036 DUT x stuck-at-0 -> err_count=16, first_fail=0x64, first_fail_valid=1, pass=0.
REQ-037 DUT y stuck-at-1 -> err_count=16, first_fail=0x2C; DUT z inverted -> err_count=128, first_fail=0x00.
REQ-038 SETTLE=3, abort asserted 50 cycles after start -> busy=0 next cycle, no done; err_count and dut_in hold partial values (dut_in=0x0C).
REQ-039 start re-pulsed mid-sweep -> no restart, total latency unchanged; start+abort together in IDLE -> busy stays 0.
REQ-040 rst asserted mid-sweep -> all outputs equal REQ-033 values after the next edge; a subsequent start runs a full clean sweep.
